// File: rtl/rs_entry_allocator_if.sv
// Handshake bundle between the reservation-station write side and its
// neighbours: command intake, oldest-first issue and completion return.
interface rs_entry_allocator_if #(
  parameter int DATA_W = 32
);
  // Command intake
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  // Issue of the oldest waiting entry
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_id;
  logic [DATA_W-1:0] out_data;

  // Completion return
  logic              done_valid;
  logic [3:0]        done_id;

  // Environment side: offers commands, accepts issues, returns completions
  modport master (
    output in_valid, in_data, out_ready, done_valid, done_id,
    input  in_ready, out_valid, out_id, out_data
  );

  // Allocator side
  modport slave (
    input  in_valid, in_data, out_ready, done_valid, done_id,
    output in_ready, out_valid, out_id, out_data
  );
endinterface

// File: rtl/rs_entry_allocator.sv
// Write-side manager of an 8-entry reservation station. Publishes the free
// vector to an external first-free monitor, allocates the entry the monitor
// names, issues waiting entries oldest-first and frees an entry when its
// completion ID comes back. Illegal completions raise a sticky error.
module rs_entry_allocator #(
  parameter int NUM_ENTRIES = 8,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [NUM_ENTRIES-1:0] rs_free,
  input  logic [3:0]             fe_id,
  rs_entry_allocator_if.slave    bus,
  output logic [3:0]             occupancy,
  output logic                   err
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_WAIT,
    ST_ISSUED
  } entry_state_e;

  entry_state_e      state_q [NUM_ENTRIES];
  entry_state_e      state_d [NUM_ENTRIES];
  logic [DATA_W-1:0] payload [NUM_ENTRIES];

  // Age queue: circular buffer of 1-based IDs for entries in WAIT.
  // It never holds more than NUM_ENTRIES IDs, so it cannot overflow.
  logic [3:0]        age_q [NUM_ENTRIES];
  logic [IDX_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  wr_ptr;
  logic [3:0]        q_count;

  logic              fe_ok;
  logic [IDX_W-1:0]  fe_idx;
  logic              alloc;
  logic [3:0]        head_id;
  logic [IDX_W-1:0]  head_idx;
  logic              issue;
  logic              done_ok;
  logic [IDX_W-1:0]  done_idx;
  logic              done_legal;
  logic              done_bad;

  // IDs are 1-based; 0 and anything above the depth mean "no entry".
  assign fe_ok    = (fe_id != 4'd0) && (fe_id <= 4'(NUM_ENTRIES));
  assign fe_idx   = fe_id[IDX_W-1:0] - IDX_W'(1);
  assign done_ok  = (bus.done_id != 4'd0) && (bus.done_id <= 4'(NUM_ENTRIES));
  assign done_idx = bus.done_id[IDX_W-1:0] - IDX_W'(1);

  // The monitor's ID is one cycle old; re-checking rs_free rejects the entry
  // taken on the previous edge, which produces the 1-in-2 allocation bubble.
  assign bus.in_ready = !rst && fe_ok && rs_free[fe_idx];
  assign alloc        = bus.in_valid && bus.in_ready;

  assign head_id       = age_q[rd_ptr];
  assign head_idx      = head_id[IDX_W-1:0] - IDX_W'(1);
  assign bus.out_valid = (q_count != 4'd0);
  assign bus.out_id    = bus.out_valid ? head_id : 4'd0;
  assign bus.out_data  = bus.out_valid ? payload[head_idx] : '0;
  assign issue         = bus.out_valid && bus.out_ready;

  // Only an ISSUED entry may complete; an entry being allocated is FREE now.
  assign done_legal = bus.done_valid && done_ok && (state_q[done_idx] == ST_ISSUED);
  assign done_bad   = bus.done_valid && !done_legal;

  // Entry state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= ST_FREE;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= state_d[i];
    end
  end

  // Entry next-state: alloc, issue and done always target distinct entries
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      // NOTE: default every element first so no path leaves it unassigned
      // (which would infer a latch).
      state_d[i] = state_q[i];
      if (alloc && (fe_idx == IDX_W'(i)))         state_d[i] = ST_WAIT;
      if (issue && (head_idx == IDX_W'(i)))       state_d[i] = ST_ISSUED;
      if (done_legal && (done_idx == IDX_W'(i)))  state_d[i] = ST_FREE;
    end
  end

  // Entry outputs: free vector for the monitor
  always_comb begin
    rs_free = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) rs_free[i] = (state_q[i] == ST_FREE);
  end

  // Payload and age-queue storage writes
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; entries are only read once the
    // state machine marks them WAIT, and out_data is masked while empty.
    if (alloc) begin
      payload[fe_idx] <= bus.in_data;
      age_q[wr_ptr]   <= fe_id;
    end
  end

  // Queue pointers, occupancy and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_count   <= 4'd0;
      occupancy <= 4'd0;
      err       <= 1'b0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + IDX_W'(1);
      if (issue) rd_ptr <= rd_ptr + IDX_W'(1);
      q_count   <= q_count + {3'b000, alloc} - {3'b000, issue};
      occupancy <= occupancy + {3'b000, alloc} - {3'b000, done_legal};
      if (done_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_entry_allocator.sv
// Bench for rs_entry_allocator: a registered first-free monitor closes the
// loop, directed sequences and a vector table cover the corner cases, and a
// random phase is compared every cycle against an entry/queue reference model.
module tb_rs_entry_allocator;

  localparam int DATA_W = 32;
  localparam int M_FREE = 0, M_WAIT = 1, M_ISSUED = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rs_free;
  logic [3:0]        fe_id;
  logic [3:0]        occupancy;
  logic              err;

  rs_entry_allocator_if #(.DATA_W(DATA_W)) bus ();

  rs_entry_allocator #(.NUM_ENTRIES(8), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rs_free   (rs_free),
    .fe_id     (fe_id),
    .bus       (bus),
    .occupancy (occupancy),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] first_free(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  // Free-entry monitor: registered lowest-set-bit encoder of rs_free
  always_ff @(posedge clk) fe_id <= rst ? 4'd0 : first_free(rs_free);

  // ---------------- reference model ----------------
  int          m_st [8];
  logic [31:0] m_pay [8];
  int          m_q [$];
  bit          m_err;
  logic [3:0]  m_fe;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_free_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = (m_st[i] == M_FREE);
    return v;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_st[i] != M_FREE) n++;
    return n;
  endfunction

  function automatic bit m_in_ready();
    logic [7:0] v = m_free_vec();
    if (rst || m_fe == 4'd0 || m_fe > 4'd8) return 1'b0;
    return v[m_fe - 4'd1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_st[i] = M_FREE;
    m_q.delete();
    m_err = 1'b0;
    m_fe  = 4'd0;
  endtask

  task automatic model_check();
    int hid;
    check("rs_free", rs_free, m_free_vec());
    check("in_ready", bus.in_ready, m_in_ready());
    check("out_valid", bus.out_valid, m_q.size() > 0);
    hid = (m_q.size() > 0) ? m_q[0] : 0;
    check("out_id", bus.out_id, hid);
    check("out_data", bus.out_data, (hid > 0) ? m_pay[hid-1] : 32'd0);
    check("occupancy", occupancy, m_occ());
    check("err", err, m_err);
  endtask

  task automatic model_update();
    bit         acc, iss, legal;
    logic [3:0] fe_next;
    int         d;
    if (rst) begin
      model_reset();
      return;
    end
    acc     = bus.in_valid && m_in_ready();
    iss     = (m_q.size() > 0) && bus.out_ready;
    d       = int'(bus.done_id);
    legal   = bus.done_valid && d >= 1 && d <= 8 && m_st[(d >= 1 && d <= 8) ? d-1 : 0] == M_ISSUED;
    fe_next = first_free(m_free_vec());
    if (iss) begin
      m_st[m_q[0]-1] = M_ISSUED;
      void'(m_q.pop_front());
    end
    if (legal) m_st[d-1] = M_FREE;
    else if (bus.done_valid) m_err = 1'b1;
    if (acc) begin
      m_st[m_fe-1]  = M_WAIT;
      m_pay[m_fe-1] = bus.in_data;
      m_q.push_back(int'(m_fe));
    end
    m_fe = fe_next;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_id    = 4'd0;
  endtask

  task automatic run_cycle();
    sample();
    advance();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    bit          in_valid;
    logic [31:0] in_data;
    bit          out_ready;
    bit          done_valid;
    logic [3:0]  done_id;
    bit          e_in_ready;
    bit          e_out_valid;
    logic [3:0]  e_out_id;
    logic [31:0] e_out_data;
    logic [7:0]  e_rs_free;
    logic [3:0]  e_occ;
    bit          e_err;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input string nm, input bit iv, input logic [31:0] idat,
                              input bit ordy, input bit dv, input logic [3:0] did,
                              input bit eir, input bit eov, input logic [3:0] eid,
                              input logic [31:0] edat, input logic [7:0] efree,
                              input logic [3:0] eocc, input bit eerr);
    vec_t v;
    v.name = nm; v.in_valid = iv; v.in_data = idat; v.out_ready = ordy;
    v.done_valid = dv; v.done_id = did; v.e_in_ready = eir; v.e_out_valid = eov;
    v.e_out_id = eid; v.e_out_data = edat; v.e_rs_free = efree; v.e_occ = eocc;
    v.e_err = eerr;
    return v;
  endfunction

  initial begin
    int         n_acc;
    int         k;
    bit         got;
    int         iss_ids [$];

    // Issue drain from the full state: IDs 1..8, payloads A0..A7
    for (int r = 0; r < 8; r++)
      vecs.push_back(mk($sformatf("issue%0d", r), 0, 0, 1, 0, 0,
                        0, 1, 4'(r + 1), 32'hA0 + r, 8'h00, 8, 0));
    // Free 3 then 6, reallocate them with the stale-ID bubble between
    vecs.push_back(mk("done3",     0, 0,      0, 1, 3,  0, 0, 0, 0,      8'h00, 8, 0));
    vecs.push_back(mk("done6",     0, 0,      0, 1, 6,  0, 0, 0, 0,      8'h04, 7, 0));
    vecs.push_back(mk("alloc3",    1, 32'hB3, 0, 0, 0,  1, 0, 0, 0,      8'h24, 6, 0));
    vecs.push_back(mk("stale3",    1, 32'hEE, 0, 0, 0,  0, 1, 3, 32'hB3, 8'h20, 7, 0));
    vecs.push_back(mk("alloc6",    1, 32'hB6, 0, 0, 0,  1, 1, 3, 32'hB3, 8'h20, 7, 0));
    // Cycle entry 5 back to WAIT, then three illegal completions
    vecs.push_back(mk("done5",     0, 0,      0, 1, 5,  0, 1, 3, 32'hB3, 8'h00, 8, 0));
    vecs.push_back(mk("lag5",      1, 32'hC5, 0, 0, 0,  0, 1, 3, 32'hB3, 8'h10, 7, 0));
    vecs.push_back(mk("alloc5",    1, 32'hC5, 0, 0, 0,  1, 1, 3, 32'hB3, 8'h10, 7, 0));
    vecs.push_back(mk("bad_wait5", 0, 0,      0, 1, 5,  0, 1, 3, 32'hB3, 8'h00, 8, 0));
    vecs.push_back(mk("bad_id0",   0, 0,      0, 1, 0,  0, 1, 3, 32'hB3, 8'h00, 8, 1));
    vecs.push_back(mk("bad_id12",  0, 0,      0, 1, 12, 0, 1, 3, 32'hB3, 8'h00, 8, 1));
    // Alloc, issue and done on distinct entries in one cycle
    vecs.push_back(mk("done1",     0, 0,      0, 1, 1,  0, 1, 3, 32'hB3, 8'h00, 8, 1));
    vecs.push_back(mk("lag1",      0, 0,      0, 0, 0,  0, 1, 3, 32'hB3, 8'h01, 7, 1));
    vecs.push_back(mk("triple",    1, 32'hD1, 1, 1, 2,  1, 1, 3, 32'hB3, 8'h01, 7, 1));
    vecs.push_back(mk("tail6",     0, 0,      1, 0, 0,  0, 1, 6, 32'hB6, 8'h02, 7, 1));
    vecs.push_back(mk("tail5",     0, 0,      1, 0, 0,  1, 1, 5, 32'hC5, 8'h02, 7, 1));
    vecs.push_back(mk("tail1",     0, 0,      1, 0, 0,  1, 1, 1, 32'hD1, 8'h02, 7, 1));
    vecs.push_back(mk("empty",     0, 0,      0, 0, 0,  1, 0, 0, 0,      8'h02, 7, 1));

    // ---- reset ----
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    sample();
    check("rst_rs_free", rs_free, 8'hFF);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_id", bus.out_id, 4'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_occ", occupancy, 4'd0);
    check("rst_err", err, 1'b0);
    advance();
    rst = 1'b0;

    // ---- fill: accepts on alternating cycles, starting 1 cycle after reset ----
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA0 + n_acc;
      sample();
      check($sformatf("fill_in_ready%0d", c), bus.in_ready, (c % 2 == 1) && (c <= 15));
      if (bus.in_ready) n_acc++;
      advance();
    end
    drive_idle();

    // ---- vector table ----
    foreach (vecs[i]) begin
      bus.in_valid   = vecs[i].in_valid;
      bus.in_data    = vecs[i].in_data;
      bus.out_ready  = vecs[i].out_ready;
      bus.done_valid = vecs[i].done_valid;
      bus.done_id    = vecs[i].done_id;
      sample();
      check({vecs[i].name, "/in_ready"}, bus.in_ready, vecs[i].e_in_ready);
      check({vecs[i].name, "/out_valid"}, bus.out_valid, vecs[i].e_out_valid);
      check({vecs[i].name, "/out_id"}, bus.out_id, vecs[i].e_out_id);
      check({vecs[i].name, "/out_data"}, bus.out_data, vecs[i].e_out_data);
      check({vecs[i].name, "/rs_free"}, rs_free, vecs[i].e_rs_free);
      check({vecs[i].name, "/occ"}, occupancy, vecs[i].e_occ);
      check({vecs[i].name, "/err"}, err, vecs[i].e_err);
      advance();
    end
    drive_idle();

    // ---- mid-operation reset with 5 live entries and a pending issue ----
    foreach (iss_ids[i]) iss_ids.delete(i);
    for (int d = 1; d <= 4; d++) begin
      if (d == 2) continue;
      bus.done_valid = 1'b1;
      bus.done_id    = 4'(d);
      run_cycle();
    end
    drive_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h5A5A0001;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      sample();
      got = bus.in_ready;
      advance();
    end
    check("s6_prefill_accept", got, 1'b1);
    drive_idle();
    sample();
    check("s6_pre_occ", occupancy, 4'd5);
    check("s6_pre_out_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    sample();
    check("s6_rs_free", rs_free, 8'hFF);
    check("s6_out_valid", bus.out_valid, 1'b0);
    check("s6_occ", occupancy, 4'd0);
    check("s6_err", err, 1'b0);
    advance();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h600D0001;
    got = 1'b0;
    k   = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      sample();
      got = bus.in_ready;
      if (!got) k++;
      advance();
    end
    check("s6_post_accept", got, 1'b1);
    check("s6_post_latency", k, 0);
    drive_idle();
    sample();
    check("s6_post_out_id", bus.out_id, 4'd1);
    check("s6_post_out_data", bus.out_data, 32'h600D0001);
    advance();

    // ---- randomized phase against the reference model ----
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(199) == 0);
      bus.in_valid   = ($urandom_range(9) < 7);
      bus.in_data    = $urandom;
      bus.out_ready  = ($urandom_range(1) == 1);
      bus.done_valid = ($urandom_range(9) < 4);
      iss_ids.delete();
      for (int i = 0; i < 8; i++) if (m_st[i] == M_ISSUED) iss_ids.push_back(i + 1);
      if ($urandom_range(9) < 8 && iss_ids.size() > 0)
        bus.done_id = 4'(iss_ids[$urandom_range(iss_ids.size() - 1)]);
      else
        bus.done_id = 4'($urandom_range(15));
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
